// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: decodes op_fun into a registered ALU control/operand pair,
// or runs a WIDTH-cycle unsigned shift-add multiply and reports the double-width product.
module alu_op_sequencer #(
    parameter int WIDTH    = 8,
    parameter int IMM_W    = 4,
    parameter int SIGN_EXT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    output logic             ready,
    input  logic [3:0]       op_fun,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] mem2_b,
    input  logic [IMM_W-1:0] inst_b,
    input  logic [IMM_W-1:0] lsw_b,
    output logic [2:0]       alu_control,
    output logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    output logic             mul_done,
    output logic [WIDTH-1:0] prod_lo,
    output logic [WIDTH-1:0] prod_hi
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_MUL
    } state_t;

    state_t               state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [WIDTH:0]       upper_sum;
    logic [CNT_W-1:0]     count;

    logic [2:0]           dec_ctrl;
    logic [WIDTH-1:0]     dec_b;
    logic                 dec_mul;

    function automatic logic [WIDTH-1:0] ext(input logic [IMM_W-1:0] imm);
        logic [WIDTH-1:0] r;
        r            = '0;
        r[IMM_W-1:0] = imm;
        if (SIGN_EXT != 0) begin
            for (int i = IMM_W; i < WIDTH; i++) r[i] = imm[IMM_W-1];
        end
        return r;
    endfunction

    assign ready = (state == ST_IDLE);

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        dec_ctrl = 3'b000;
        dec_b    = mem2_b;
        dec_mul  = 1'b0;
        if (op_fun[3]) begin
            dec_ctrl = op_fun[2:0];
        end else begin
            case (op_fun[2:0])
                3'b001:         dec_b = ext(inst_b);
                3'b010: begin
                    dec_ctrl = 3'b001;
                    dec_b    = ext(inst_b);
                end
                3'b011, 3'b100: dec_b = ext(lsw_b);
                3'b110:         dec_ctrl = 3'b101;
                3'b111:         dec_mul = 1'b1;
                default:        ;
            endcase
        end
    end

    // One shift-add step: conditionally add the multiplicand into the upper half, then shift right.
    always_comb begin
        upper_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        acc_next  = {upper_sum, acc[WIDTH-1:1]};
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            mul_done    <= 1'b0;
            alu_control <= 3'b000;
            alu_b       <= '0;
            prod_lo     <= '0;
            prod_hi     <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            count       <= '0;
        end else begin
            out_valid <= 1'b0;
            mul_done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        alu_control <= dec_ctrl;
                        alu_b       <= dec_b;
                        if (dec_mul) begin
                            mcand  <= a_in;
                            mplier <= mem2_b;
                            acc    <= '0;
                            count  <= CNT_W'(WIDTH - 1);
                            state  <= ST_MUL;
                        end else begin
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count - CNT_W'(1);
                    if (count == '0) begin
                        {prod_hi, prod_lo} <= acc_next;
                        out_valid          <= 1'b1;
                        mul_done           <= 1'b1;
                        state              <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: zero- and sign-extending instances share stimulus and are
// compared every cycle against a transaction-level model plus directed literal expectations.
module tb_alu_op_sequencer;

    localparam int W  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          valid = 1'b0;
    logic [3:0]    op_fun = '0;
    logic [W-1:0]  a_in = '0;
    logic [W-1:0]  mem2_b = '0;
    logic [IW-1:0] inst_b = '0;
    logic [IW-1:0] lsw_b = '0;

    logic          ready0, out_valid0, mul_done0;
    logic [2:0]    ctrl0;
    logic [W-1:0]  b0, lo0, hi0;
    logic          ready1, out_valid1, mul_done1;
    logic [2:0]    ctrl1;
    logic [W-1:0]  b1, lo1, hi1;

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(W), .IMM_W(IW), .SIGN_EXT(0)) dut_zx (
        .clk(clk), .reset_n(reset_n), .valid(valid), .ready(ready0), .op_fun(op_fun),
        .a_in(a_in), .mem2_b(mem2_b), .inst_b(inst_b), .lsw_b(lsw_b),
        .alu_control(ctrl0), .alu_b(b0), .out_valid(out_valid0), .mul_done(mul_done0),
        .prod_lo(lo0), .prod_hi(hi0)
    );

    alu_op_sequencer #(.WIDTH(W), .IMM_W(IW), .SIGN_EXT(1)) dut_sx (
        .clk(clk), .reset_n(reset_n), .valid(valid), .ready(ready1), .op_fun(op_fun),
        .a_in(a_in), .mem2_b(mem2_b), .inst_b(inst_b), .lsw_b(lsw_b),
        .alu_control(ctrl1), .alu_b(b1), .out_valid(out_valid1), .mul_done(mul_done1),
        .prod_lo(lo1), .prod_hi(hi1)
    );

    logic [59:0] obs;
    assign obs = {ready0, out_valid0, mul_done0, ctrl0, b0, hi0, lo0,
                  ready1, out_valid1, mul_done1, ctrl1, b1, hi1, lo1};

    int n_cmp = 0;
    int n_bad = 0;

    // Transaction-level model: busy countdown, pending product, last decoded pair.
    int          m_busy = 0;
    bit          m_ov = 1'b0;
    bit          m_md = 1'b0;
    logic [2:0]  m_ctrl = '0;
    logic [7:0]  m_b0 = '0;
    logic [7:0]  m_b1 = '0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_pend = '0;

    function automatic logic [7:0] ext_ref(input logic [3:0] imm, input bit sx);
        int v;
        v = int'(imm);
        if (sx && v >= 8) v = v + 240;
        return 8'(v);
    endfunction

    function automatic logic [59:0] exp_vec();
        logic rdy;
        rdy = (m_busy == 0);
        return {rdy, m_ov, m_md, m_ctrl, m_b0, m_prod,
                rdy, m_ov, m_md, m_ctrl, m_b1, m_prod};
    endfunction

    task automatic model_edge();
        if (!reset_n) begin
            m_busy = 0; m_ov = 1'b0; m_md = 1'b0;
            m_ctrl = '0; m_b0 = '0; m_b1 = '0; m_prod = '0;
        end else begin
            m_ov = 1'b0;
            m_md = 1'b0;
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) begin
                    m_ov = 1'b1; m_md = 1'b1; m_prod = m_pend;
                end
            end else if (valid) begin
                m_ctrl = 3'd0;
                m_b0   = mem2_b;
                m_b1   = mem2_b;
                if (op_fun == 4'd7) begin
                    m_busy = W;
                    m_pend = 16'(a_in) * 16'(mem2_b);
                end else begin
                    m_ov = 1'b1;
                    if (op_fun >= 4'd8) begin
                        m_ctrl = 3'(op_fun - 4'd8);
                    end else if (op_fun == 4'd1 || op_fun == 4'd2) begin
                        m_b0 = ext_ref(inst_b, 1'b0);
                        m_b1 = ext_ref(inst_b, 1'b1);
                        if (op_fun == 4'd2) m_ctrl = 3'd1;
                    end else if (op_fun == 4'd3 || op_fun == 4'd4) begin
                        m_b0 = ext_ref(lsw_b, 1'b0);
                        m_b1 = ext_ref(lsw_b, 1'b1);
                    end else if (op_fun == 4'd6) begin
                        m_ctrl = 3'd5;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_inputs();
        a_in   = W'($urandom);
        mem2_b = W'($urandom);
        inst_b = IW'($urandom);
        lsw_b  = IW'($urandom);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        valid   = 1'b1;
        op_fun  = 4'd7;
        rand_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_model got %h want %h", obs, exp_vec());
            end
        end
        n_cmp++;
        if ({ready0, out_valid0, mul_done0, ctrl0, b0, hi0, lo0} !== {3'b100, 27'd0}) begin
            n_bad++;
            $display("FAIL reset_literal got %h want %h",
                     {ready0, out_valid0, mul_done0, ctrl0, b0, hi0, lo0}, {3'b100, 27'd0});
        end
        reset_n = 1'b1;
        valid   = 1'b0;
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL reset_release got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_decode();
        logic [3:0] t_op   [8] = '{4'b0001, 4'b1101, 4'b0101, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b0000};
        logic [7:0] t_mem  [8] = '{8'h11, 8'h33, 8'h5C, 8'h44, 8'h55, 8'h21, 8'h66, 8'h77};
        logic [3:0] t_imm  [8] = '{4'hA, 4'h3, 4'hE, 4'h1, 4'h9, 4'hB, 4'h2, 4'hF};
        logic [3:0] t_lsw  [8] = '{4'h5, 4'hD, 4'h8, 4'h7, 4'hC, 4'h6, 4'hC, 4'h9};
        logic [2:0] t_ctrl [8] = '{3'b000, 3'b101, 3'b000, 3'b000, 3'b001, 3'b101, 3'b000, 3'b000};
        logic [7:0] t_bz   [8] = '{8'h0A, 8'h33, 8'h5C, 8'h07, 8'h09, 8'h21, 8'h0C, 8'h77};
        logic [7:0] t_bs   [8] = '{8'hFA, 8'h33, 8'h5C, 8'h07, 8'hF9, 8'h21, 8'hFC, 8'h77};
        for (int i = 0; i < 8; i++) begin
            a_in   = W'($urandom);
            op_fun = t_op[i];
            mem2_b = t_mem[i];
            inst_b = t_imm[i];
            lsw_b  = t_lsw[i];
            valid  = 1'b1;
            tick();
            valid = 1'b0;
            n_cmp++;
            if ({out_valid0, mul_done0, ctrl0, b0, out_valid1, mul_done1, ctrl1, b1}
                !== {2'b10, t_ctrl[i], t_bz[i], 2'b10, t_ctrl[i], t_bs[i]}) begin
                n_bad++;
                $display("FAIL decode_op%b got %h want %h", t_op[i],
                         {out_valid0, mul_done0, ctrl0, b0, out_valid1, mul_done1, ctrl1, b1},
                         {2'b10, t_ctrl[i], t_bz[i], 2'b10, t_ctrl[i], t_bs[i]});
            end
            rand_inputs();
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL decode_hold_op%b got %h want %h", t_op[i], obs, exp_vec());
            end
        end
    endtask

    task automatic test_mul_max();
        int low;
        op_fun = 4'b0111;
        a_in   = 8'hFF;
        mem2_b = 8'hFF;
        valid  = 1'b1;
        tick();
        low = 0;
        while (ready0 === 1'b0 && low < 20) begin
            low++;
            op_fun = 4'($urandom_range(0, 6));
            rand_inputs();
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL mul_max_busy cycle %0d got %h want %h", low, obs, exp_vec());
            end
        end
        valid = 1'b0;
        n_cmp++;
        if (low !== W) begin
            n_bad++;
            $display("FAIL mul_max_ready_low got %0d cycles want %0d", low, W);
        end
        n_cmp++;
        if ({out_valid0, mul_done0, hi0, lo0, out_valid1, mul_done1, hi1, lo1}
            !== {2'b11, 16'hFE01, 2'b11, 16'hFE01}) begin
            n_bad++;
            $display("FAIL mul_max_product got %h want %h",
                     {out_valid0, mul_done0, hi0, lo0, out_valid1, mul_done1, hi1, lo1},
                     {2'b11, 16'hFE01, 2'b11, 16'hFE01});
        end
        tick();
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL mul_max_after got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        op_fun = 4'b0111;
        rand_inputs();
        valid  = 1'b1;
        tick();
        op_fun = 4'b0010;
        inst_b = 4'h6;
        waited = 0;
        while (out_valid0 !== 1'b1 && waited < 20) begin
            waited++;
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL b2b_busy cycle %0d got %h want %h", waited, obs, exp_vec());
            end
        end
        n_cmp++;
        if (out_valid0 !== 1'b1 || waited !== W) begin
            n_bad++;
            $display("FAIL b2b_mul_done got out_valid=%b after %0d cycles want 1 after %0d",
                     out_valid0, waited, W);
        end
        tick();
        valid = 1'b0;
        n_cmp++;
        if ({ready0, out_valid0, mul_done0, ctrl0, b0} !== {3'b110, 3'b001, 8'h06}) begin
            n_bad++;
            $display("FAIL b2b_second got %h want %h",
                     {ready0, out_valid0, mul_done0, ctrl0, b0}, {3'b110, 3'b001, 8'h06});
        end
        n_cmp++;
        if (obs !== exp_vec()) begin
            n_bad++;
            $display("FAIL b2b_model got %h want %h", obs, exp_vec());
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        op_fun = 4'b0111;
        rand_inputs();
        valid  = 1'b1;
        tick();
        valid = 1'b0;
        tick();
        tick();
        tick();
        reset_n = 1'b0;
        valid   = 1'b1;
        tick();
        n_cmp++;
        if ({ready0, out_valid0, mul_done0, ctrl0, b0, hi0, lo0} !== {3'b100, 27'd0}) begin
            n_bad++;
            $display("FAIL midreset_literal got %h want %h",
                     {ready0, out_valid0, mul_done0, ctrl0, b0, hi0, lo0}, {3'b100, 27'd0});
        end
        reset_n = 1'b1;
        op_fun  = 4'b0111;
        a_in    = 8'h03;
        mem2_b  = 8'h05;
        tick();
        valid = 1'b0;
        for (int k = 1; k <= W; k++) begin
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL midreset_mul cycle %0d got %h want %h", k, obs, exp_vec());
            end
        end
        n_cmp++;
        if ({out_valid0, mul_done0, hi0, lo0} !== {2'b11, 16'h000F}) begin
            n_bad++;
            $display("FAIL midreset_product got %h want %h",
                     {out_valid0, mul_done0, hi0, lo0}, {2'b11, 16'h000F});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            reset_n = ($urandom_range(0, 99) != 0);
            valid   = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) op_fun = 4'b0111;
            else                           op_fun = 4'($urandom_range(0, 15));
            rand_inputs();
            tick();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cycle %0d got %h want %h", i, obs, exp_vec());
            end
        end
        reset_n = 1'b1;
        valid   = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mul_max();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
